// File: rtl/video_format_regularizer_if.sv
// AXI4-Stream video link used on both sides of the frame regularizer.
interface video_format_regularizer_if #(
  parameter int TUSER_WIDTH = 1,
  parameter int TDATA_WIDTH = 24
);
  logic [TUSER_WIDTH-1:0] tuser;
  logic                   tlast;
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;

  modport master (output tuser, tlast, tdata, tvalid, input tready);
  modport slave  (input tuser, tlast, tdata, tvalid, output tready);
endinterface

// File: rtl/video_format_regularizer.sv
// Forces raw AXI4-Stream video into frames of exactly width x height beats (pad/truncate).
// Optional stall timeout in RUN is enabled by defining VIDEO_REGULARIZER_TIMEOUT_EN.
module video_format_regularizer #(
  parameter int TUSER_WIDTH   = 1,
  parameter int TDATA_WIDTH   = 24,
  parameter int H_WIDTH       = 12,
  parameter int V_WIDTH       = 12,
  parameter int INDEX_WIDTH   = 8,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     ctl_enable,
  output logic                     ctl_busy,
  output logic [INDEX_WIDTH-1:0]   ctl_index,
  output logic [2:0]               err_status,
  input  logic                     err_clear,
  input  logic [H_WIDTH-1:0]       param_width,
  input  logic [V_WIDTH-1:0]       param_height,
  input  logic [TDATA_WIDTH-1:0]   param_fill,
  input  logic [TIMEOUT_WIDTH-1:0] param_timeout,
  video_format_regularizer_if.slave  s_axi4s,
  video_format_regularizer_if.master m_axi4s
);

  typedef enum logic [2:0] {IDLE, SYNC, RUN, FILL_LINE, SKIP_LINE, FILL_FRAME} state_e;

  localparam logic [H_WIDTH-1:0]     H_ONE   = 1;
  localparam logic [V_WIDTH-1:0]     V_ONE   = 1;
  localparam logic [INDEX_WIDTH-1:0] IDX_ONE = 1;

  state_e                 state_q, state_d;
  logic [H_WIDTH-1:0]     x_q, x_d, width_q, width_d;
  logic [V_WIDTH-1:0]     y_q, y_d, height_q, height_d;
  logic [TDATA_WIDTH-1:0] fill_q, fill_d;
  logic                   mValid_q, mValid_d, mLast_q, mLast_d;
  logic [TUSER_WIDTH-1:0] mUser_q, mUser_d;
  logic [TDATA_WIDTH-1:0] mData_q, mData_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic [2:0]             err_q, err_d, errSet;

  logic cke, sof, atOrigin, lineEnd, frameEnd, sReady, sHs;
  logic emit, useInput, enterSync, timeoutHit;

  assign cke      = !mValid_q || m_axi4s.tready;
  assign sof      = s_axi4s.tuser[0];
  assign atOrigin = (x_q == '0) && (y_q == '0);
  assign lineEnd  = (x_q == (width_q - H_ONE));
  assign frameEnd = lineEnd && (y_q == (height_q - V_ONE));
  assign sHs      = s_axi4s.tvalid && sReady;

`ifdef VIDEO_REGULARIZER_TIMEOUT_EN
  localparam logic [TIMEOUT_WIDTH-1:0] T_ONE = 1;
  logic [TIMEOUT_WIDTH-1:0] timer_q, timer_d;

  assign timeoutHit = (state_q == RUN) && (param_timeout != '0) && (timer_q >= param_timeout);

  // Idle-input cycles in RUN; only counted while the output stage could have moved.
  always_comb begin
    timer_d = timer_q;
    if (state_q != RUN) begin
      timer_d = '0;
    end else if (cke) begin
      if (sHs) begin
        timer_d = '0;
      end else if (!s_axi4s.tvalid && !timeoutHit) begin
        timer_d = timer_q + T_ONE;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  logic unusedTimeout;
  assign unusedTimeout = ^param_timeout;
  assign timeoutHit    = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      width_q  <= H_ONE;
      height_q <= V_ONE;
      fill_q   <= '0;
      mValid_q <= 1'b0;
      mUser_q  <= '0;
      mLast_q  <= 1'b0;
      mData_q  <= '0;
      index_q  <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      width_q  <= width_d;
      height_q <= height_d;
      fill_q   <= fill_d;
      mValid_q <= mValid_d;
      mUser_q  <= mUser_d;
      mLast_q  <= mLast_d;
      mData_q  <= mData_d;
      index_q  <= index_d;
      err_q    <= err_d;
    end
  end

  // IDLE and SKIP_LINE only discard input, so they move regardless of the output stage.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    width_d   = width_q;
    height_d  = height_q;
    fill_d    = fill_q;
    mValid_d  = mValid_q;
    mUser_d   = mUser_q;
    mLast_d   = mLast_q;
    mData_d   = mData_q;
    index_d   = index_q;
    errSet    = '0;
    emit      = 1'b0;
    useInput  = 1'b0;
    enterSync = 1'b0;

    unique case (state_q)
      IDLE: begin
        x_d = '0;
        y_d = '0;
        if (ctl_enable) begin
          state_d   = SYNC;
          enterSync = 1'b1;
        end
      end
      SYNC: begin
        if (cke) begin
          if (!ctl_enable) begin
            state_d = IDLE;
          end else if (s_axi4s.tvalid && sof) begin
            emit     = 1'b1;
            useInput = 1'b1;
          end
        end
      end
      RUN: begin
        if (cke) begin
          if (timeoutHit || (s_axi4s.tvalid && sof && !atOrigin)) begin
            errSet[2] = 1'b1;
            state_d   = FILL_FRAME;
          end else if (s_axi4s.tvalid) begin
            emit     = 1'b1;
            useInput = 1'b1;
          end
        end
      end
      SKIP_LINE: begin
        if (s_axi4s.tvalid && sof) begin
          errSet[2] = 1'b1;
          state_d   = FILL_FRAME;
        end else if (s_axi4s.tvalid && s_axi4s.tlast) begin
          state_d = RUN;
        end
      end
      FILL_LINE, FILL_FRAME: begin
        emit = cke;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (cke) begin
      mValid_d = emit;
    end

    if (emit) begin
      mUser_d    = useInput ? s_axi4s.tuser : '0;
      mUser_d[0] = atOrigin;
      mLast_d    = lineEnd;
      mData_d    = useInput ? s_axi4s.tdata : fill_q;
      errSet[1]  = useInput && lineEnd && !s_axi4s.tlast;
      errSet[0]  = useInput && !lineEnd && s_axi4s.tlast;
      if (lineEnd) begin
        x_d = '0;
        y_d = frameEnd ? '0 : (y_q + V_ONE);
      end else begin
        x_d = x_q + H_ONE;
      end
      if (frameEnd) begin
        index_d = index_q + IDX_ONE;
        if (ctl_enable) begin
          state_d   = SYNC;
          enterSync = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end else if (errSet[1]) begin
        state_d = SKIP_LINE;
      end else if (errSet[0]) begin
        state_d = FILL_LINE;
      end else if ((state_q == FILL_LINE) && lineEnd) begin
        state_d = RUN;
      end else if (state_q == SYNC) begin
        state_d = RUN;
      end
    end

    if (enterSync) begin
      width_d  = (param_width == '0) ? H_ONE : param_width;
      height_d = (param_height == '0) ? V_ONE : param_height;
      fill_d   = param_fill;
    end

    err_d = (err_clear ? 3'b000 : err_q) | errSet;
  end

  // A misplaced SOF or a pending timeout must stay unconsumed so SYNC can pick it up.
  always_comb begin
    sReady = 1'b0;
    unique case (state_q)
      IDLE:      sReady = 1'b1;
      SYNC:      sReady = cke;
      RUN:       sReady = cke && !(sof && !atOrigin) && !timeoutHit;
      SKIP_LINE: sReady = !sof;
      default:   sReady = 1'b0;
    endcase
  end

  assign s_axi4s.tready = sReady;
  assign m_axi4s.tvalid = mValid_q;
  assign m_axi4s.tuser  = mUser_q;
  assign m_axi4s.tlast  = mLast_q;
  assign m_axi4s.tdata  = mData_q;
  assign ctl_busy       = (state_q != IDLE);
  assign ctl_index      = index_q;
  assign err_status     = err_q;

endmodule

// File: tb/tb_video_format_regularizer.sv
// Scoreboard bench for video_format_regularizer: directed frames, expected beats queued at issue.
module tb_video_format_regularizer;

  localparam logic [23:0] FILL = 24'hABCDEF;

  typedef struct packed {
    logic        sof;
    logic        last;
    logic [23:0] data;
  } beat_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        ctl_enable = 1'b0;
  logic        err_clear = 1'b0;
  logic        ctl_busy;
  logic [7:0]  ctl_index;
  logic [2:0]  err_status;
  logic [11:0] param_width = 12'd4;
  logic [11:0] param_height = 12'd2;
  logic [23:0] param_fill = FILL;
  logic [15:0] param_timeout = 16'd0;

  logic randomReady = 1'b0;
  logic readyLevel = 1'b1;

  beat_t expQ[$];
  int    compared = 0;
  int    mismatched = 0;

  video_format_regularizer_if #(.TUSER_WIDTH(1), .TDATA_WIDTH(24)) sIf ();
  video_format_regularizer_if #(.TUSER_WIDTH(1), .TDATA_WIDTH(24)) mIf ();

  video_format_regularizer dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .ctl_enable    (ctl_enable),
    .ctl_busy      (ctl_busy),
    .ctl_index     (ctl_index),
    .err_status    (err_status),
    .err_clear     (err_clear),
    .param_width   (param_width),
    .param_height  (param_height),
    .param_fill    (param_fill),
    .param_timeout (param_timeout),
    .s_axi4s       (sIf),
    .m_axi4s       (mIf)
  );

  always #5 aclk = ~aclk;

  // Output ready is changed just after each rising edge, either fixed or random.
  initial begin
    mIf.tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      mIf.tready = randomReady ? 1'($urandom_range(0, 1)) : readyLevel;
    end
  end

  // Monitor: at each falling edge, a valid&ready beat is the one accepted at the next rise.
  initial begin
    beat_t got;
    beat_t exp;
    beat_t held;
    logic  heldValid;
    heldValid = 1'b0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        heldValid = 1'b0;
      end else if (mIf.tvalid) begin
        got = {mIf.tuser[0], mIf.tlast, mIf.tdata};
        if (heldValid) begin
          compared++;
          if (got !== held) begin
            mismatched++;
            $display("[TB] FAIL stable: got sof=%0b last=%0b data=%h required sof=%0b last=%0b data=%h",
                     got.sof, got.last, got.data, held.sof, held.last, held.data);
          end
        end
        if (mIf.tready) begin
          heldValid = 1'b0;
          compared++;
          if (expQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL beat: got unexpected sof=%0b last=%0b data=%h required none",
                     got.sof, got.last, got.data);
          end else begin
            exp = expQ.pop_front();
            if (got !== exp) begin
              mismatched++;
              $display("[TB] FAIL beat: got sof=%0b last=%0b data=%h required sof=%0b last=%0b data=%h",
                       got.sof, got.last, got.data, exp.sof, exp.last, exp.data);
            end
          end
        end else begin
          held      = got;
          heldValid = 1'b1;
        end
      end else if (heldValid) begin
        compared++;
        mismatched++;
        heldValid = 1'b0;
        $display("[TB] FAIL stable: got tvalid=0 required tvalid=1 until accepted");
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic expectBeat(input logic sof, input logic last, input logic [23:0] data);
    expQ.push_back({sof, last, data});
  endtask

  task automatic applyStimulus(input logic sof, input logic last, input logic [23:0] data);
    bit done = 1'b0;
    sIf.tuser  = sof;
    sIf.tlast  = last;
    sIf.tdata  = data;
    sIf.tvalid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge aclk);
      if (sIf.tready) done = 1'b1;
      @(posedge aclk);
      #1;
    end
    sIf.tvalid = 1'b0;
    sIf.tuser  = 1'b0;
    sIf.tlast  = 1'b0;
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL handshake: got no s_tready for data=%h required acceptance", data);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic sendCleanFrame(input int w, input int h, input int base);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        expectBeat(x == 0 && y == 0, x == w - 1, 24'(base + y * 16 + x));
        applyStimulus(x == 0 && y == 0, x == w - 1, 24'(base + y * 16 + x));
      end
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 3000) begin
      @(posedge aclk);
      n++;
    end
    repeat (3) @(posedge aclk);
    #1;
    if (expQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: got %0d beats outstanding required 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic clearErr();
    err_clear = 1'b1;
    @(posedge aclk);
    #1;
    err_clear = 1'b0;
    @(posedge aclk);
    #1;
  endtask

  task automatic restart(input logic [11:0] w, input logic [11:0] h);
    ctl_enable = 1'b0;
    repeat (4) @(posedge aclk);
    #1;
    param_width  = w;
    param_height = h;
    ctl_enable   = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
  endtask

  initial begin
    sIf.tvalid = 1'b0;
    sIf.tuser  = 1'b0;
    sIf.tlast  = 1'b0;
    sIf.tdata  = '0;
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("reset busy", 32'(ctl_busy), 0);
    checkOutput("reset index", 32'(ctl_index), 0);
    checkOutput("reset err", 32'(err_status), 0);
    checkOutput("reset m_tvalid", 32'(mIf.tvalid), 0);
    checkOutput("reset m_tuser", 32'(mIf.tuser), 0);
    checkOutput("reset m_tlast", 32'(mIf.tlast), 0);
    checkOutput("reset m_tdata", 32'(mIf.tdata), 0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    $display("[TB] clean frames");
    ctl_enable = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("busy in sync", 32'(ctl_busy), 1);
    sendCleanFrame(4, 2, 32'h100);
    sendCleanFrame(4, 2, 32'h200);
    waitDrain();
    checkOutput("clean index", 32'(ctl_index), 2);
    checkOutput("clean err", 32'(err_status), 0);

    $display("[TB] short line");
    expectBeat(1'b1, 1'b0, 24'h11);
    applyStimulus(1'b1, 1'b0, 24'h11);
    expectBeat(1'b0, 1'b0, 24'h22);
    expectBeat(1'b0, 1'b0, FILL);
    expectBeat(1'b0, 1'b1, FILL);
    applyStimulus(1'b0, 1'b1, 24'h22);
    for (int x = 0; x < 4; x++) begin
      expectBeat(1'b0, x == 3, 24'(32'h130 + x));
      applyStimulus(1'b0, x == 3, 24'(32'h130 + x));
    end
    waitDrain();
    checkOutput("short index", 32'(ctl_index), 3);
    checkOutput("short err", 32'(err_status), 32'b001);
    clearErr();
    checkOutput("err cleared", 32'(err_status), 0);

    $display("[TB] long line");
    for (int x = 0; x < 6; x++) begin
      if (x < 4) expectBeat(x == 0, x == 3, 24'(32'h31 + x));
      applyStimulus(x == 0, x == 5, 24'(32'h31 + x));
    end
    for (int x = 0; x < 4; x++) begin
      expectBeat(1'b0, x == 3, 24'(32'h41 + x));
      applyStimulus(1'b0, x == 3, 24'(32'h41 + x));
    end
    waitDrain();
    checkOutput("long index", 32'(ctl_index), 4);
    checkOutput("long err", 32'(err_status), 32'b010);
    clearErr();

    $display("[TB] early SOF");
    for (int i = 0; i < 5; i++) begin
      expectBeat(i == 0, i == 3, 24'(32'h51 + i));
      if (i == 4) begin
        expectBeat(1'b0, 1'b0, FILL);
        expectBeat(1'b0, 1'b0, FILL);
        expectBeat(1'b0, 1'b1, FILL);
      end
      applyStimulus(i == 0, i == 3, 24'(32'h51 + i));
    end
    sendCleanFrame(4, 2, 32'h600);
    waitDrain();
    checkOutput("early sof index", 32'(ctl_index), 6);
    checkOutput("early sof err", 32'(err_status), 32'b100);
    clearErr();

    $display("[TB] zero geometry treated as 1x1");
    restart(12'd0, 12'd0);
    expectBeat(1'b1, 1'b1, 24'h777);
    applyStimulus(1'b1, 1'b1, 24'h777);
    expectBeat(1'b1, 1'b1, 24'h778);
    applyStimulus(1'b1, 1'b1, 24'h778);
    waitDrain();
    checkOutput("1x1 index", 32'(ctl_index), 8);
    checkOutput("1x1 err", 32'(err_status), 0);

    $display("[TB] backpressure, garbage, mid-frame width change");
    restart(12'd3, 12'd3);
    randomReady = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, i == 2, 24'(32'hDEAD0 + i));
    for (int i = 0; i < 9; i++) begin
      if (i == 1) param_width = 12'd5;
      if (i == 5) param_width = 12'd3;
      expectBeat(i == 0, (i % 3) == 2, 24'(32'h900 + i));
      applyStimulus(i == 0, (i % 3) == 2, 24'(32'h900 + i));
    end
    sendCleanFrame(3, 3, 32'hA00);
    waitDrain();
    randomReady = 1'b0;
    readyLevel  = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    checkOutput("backpressure index", 32'(ctl_index), 10);
    checkOutput("backpressure err", 32'(err_status), 0);

`ifdef VIDEO_REGULARIZER_TIMEOUT_EN
    $display("[TB] stall timeout");
    restart(12'd4, 12'd2);
    param_timeout = 16'd10;
    for (int x = 0; x < 3; x++) begin
      expectBeat(x == 0, 1'b0, 24'(32'h81 + x));
      applyStimulus(x == 0, 1'b0, 24'(32'h81 + x));
    end
    expectBeat(1'b0, 1'b1, FILL);
    expectBeat(1'b0, 1'b0, FILL);
    expectBeat(1'b0, 1'b0, FILL);
    expectBeat(1'b0, 1'b0, FILL);
    expectBeat(1'b0, 1'b1, FILL);
    waitDrain();
    checkOutput("timeout index", 32'(ctl_index), 11);
    checkOutput("timeout err", 32'(err_status), 32'b100);
    clearErr();
    param_timeout = 16'd0;
`endif

    $display("[TB] reset mid-frame");
    readyLevel = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    applyStimulus(1'b1, 1'b0, 24'hC0FFEE);
    checkOutput("pre-reset m_tvalid", 32'(mIf.tvalid), 1);
    #2;
    aresetn = 1'b0;
    #1;
    checkOutput("mid reset m_tvalid", 32'(mIf.tvalid), 0);
    checkOutput("mid reset m_tuser", 32'(mIf.tuser), 0);
    checkOutput("mid reset m_tlast", 32'(mIf.tlast), 0);
    checkOutput("mid reset m_tdata", 32'(mIf.tdata), 0);
    checkOutput("mid reset index", 32'(ctl_index), 0);
    checkOutput("mid reset err", 32'(err_status), 0);
    checkOutput("mid reset busy", 32'(ctl_busy), 0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    checkOutput("scoreboard empty", 32'(expQ.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
